// File: rtl/mult_job_dispatcher_pkg.sv
// Shared definitions for the multiplier job dispatcher: FSM encoding and default widths.
package mult_job_dispatcher_pkg;

    localparam int unsigned L_WORD_DEF  = 4;
    localparam int unsigned L_TAG_DEF   = 4;
    localparam int unsigned L_DEPTH_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

endpackage

// File: rtl/mult_job_dispatcher_job_fifo.sv
// Synchronous job FIFO; pointers carry an extra wrap bit so full and empty are unambiguous.
module mult_job_dispatcher_job_fifo #(
    parameter int unsigned W  = 12,
    parameter int unsigned AW = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head_c,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   w_wr_ptr_nxt;
    logic [AW:0]   w_rd_ptr_nxt;
    logic          r_full;
    logic          r_empty;
    logic          w_push;
    logic          w_pop;

    assign w_push       = i_push & ~r_full;
    assign w_pop        = i_pop & ~r_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);

    // Flags are registered from next-pointer values so they line up with the pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_head_c = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full   = r_full;
    assign o_empty  = r_empty;

endmodule

// File: rtl/mult_job_dispatcher.sv
// Feeds queued operand jobs to an external sequential multiplier one at a time
// and returns each product with its tag on a valid/ready result port.
module mult_job_dispatcher
    import mult_job_dispatcher_pkg::*;
#(
    parameter int unsigned L_word  = L_WORD_DEF,
    parameter int unsigned L_tag   = L_TAG_DEF,
    parameter int unsigned L_depth = L_DEPTH_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [L_word-1:0]   in_word1,
    input  logic [L_word-1:0]   in_word2,
    input  logic [L_tag-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*L_word-1:0] out_product,
    output logic [L_tag-1:0]    out_tag,
    output logic [L_word-1:0]   word1,
    output logic [L_word-1:0]   word2,
    output logic                Start,
    input  logic                Ready,
    input  logic [2*L_word-1:0] product,
    output logic                err
);

    localparam int unsigned JOB_W = 2*L_word + L_tag;

    logic [JOB_W-1:0]    w_fifo_in;
    logic [JOB_W-1:0]    w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [L_word-1:0]   w_head_w1;
    logic [L_word-1:0]   w_head_w2;
    logic [L_tag-1:0]    w_head_tag;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [L_word-1:0]   r_word1;
    logic [L_word-1:0]   r_word2;
    logic [L_word-1:0]   w_word1_nxt;
    logic [L_word-1:0]   w_word2_nxt;
    logic [L_tag-1:0]    r_out_tag;
    logic [L_tag-1:0]    w_tag_nxt;
    logic [2*L_word-1:0] r_out_product;
    logic [2*L_word-1:0] w_product_nxt;
    logic                r_out_valid;
    logic                r_start;
    logic                r_err;
    logic                w_err_nxt;

    assign w_fifo_in = {in_tag, in_word1, in_word2};
    assign {w_head_tag, w_head_w1, w_head_w2} = w_head;
    assign w_push    = in_valid & ~w_full;

    mult_job_dispatcher_job_fifo #(
        .W  (JOB_W),
        .AW (L_depth)
    ) u_job_fifo (
        .clock    (clock),
        .reset    (reset),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (w_fifo_in),
        .o_head_c (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_word1_nxt   = r_word1;
        w_word2_nxt   = r_word2;
        w_tag_nxt     = r_out_tag;
        w_product_nxt = r_out_product;
        w_err_nxt     = r_err;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && Ready) begin
                    w_pop     = 1'b1;
                    w_tag_nxt = w_head_tag;
                    // A zero operand has a known product, so the multiplier is bypassed.
                    if ((w_head_w1 != '0) && (w_head_w2 != '0)) begin
                        w_word1_nxt = w_head_w1;
                        w_word2_nxt = w_head_w2;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_product_nxt = '0;
                        w_state_nxt   = ST_HOLD;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // The multiplier must drop Ready after Start; if not, the job is lost.
                if (Ready) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (Ready) begin
                    w_product_nxt = product;
                    w_state_nxt   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they are registered yet aligned with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word1       <= '0;
            r_word2       <= '0;
            r_out_tag     <= '0;
            r_out_product <= '0;
            r_out_valid   <= 1'b0;
            r_start       <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_word1       <= w_word1_nxt;
            r_word2       <= w_word2_nxt;
            r_out_tag     <= w_tag_nxt;
            r_out_product <= w_product_nxt;
            r_out_valid   <= (w_state_nxt == ST_HOLD);
            r_start       <= (w_state_nxt == ST_ISSUE);
            r_err         <= w_err_nxt;
        end
    end

    assign in_ready    = ~w_full;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_tag     = r_out_tag;
    assign word1       = r_word1;
    assign word2       = r_word2;
    assign Start       = r_start;
    assign err         = r_err;

endmodule

// File: tb/tb_mult_job_dispatcher.sv
// Bench for mult_job_dispatcher with a behavioural L_word-cycle sequential multiplier model.
module tb_mult_job_dispatcher;

    localparam int unsigned L_WORD = 4;
    localparam int unsigned L_TAG  = 4;

    typedef struct {
        logic [2*L_WORD-1:0] prod;
        logic [L_TAG-1:0]    tag;
    } exp_t;

    logic                clock;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [L_WORD-1:0]   in_word1;
    logic [L_WORD-1:0]   in_word2;
    logic [L_TAG-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [2*L_WORD-1:0] out_product;
    logic [L_TAG-1:0]    out_tag;
    logic [L_WORD-1:0]   word1;
    logic [L_WORD-1:0]   word2;
    logic                Start;
    logic                Ready;
    logic [2*L_WORD-1:0] product;
    logic                err;

    logic                m_ready;
    logic                force_ready;
    int                  m_cnt;
    logic [L_WORD-1:0]   m_a;
    logic [L_WORD-1:0]   m_b;

    int   checks;
    int   errors;
    int   start_cnt;
    exp_t exp_q[$];

    mult_job_dispatcher dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word1    (in_word1),
        .in_word2    (in_word2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag),
        .word1       (word1),
        .word2       (word2),
        .Start       (Start),
        .Ready       (Ready),
        .product     (product),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier model: Ready low for L_WORD cycles after Start, then product with Ready high.
    assign Ready = m_ready | force_ready;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
            m_a     <= '0;
            m_b     <= '0;
            product <= '0;
        end else if (Start && m_cnt == 0) begin
            m_ready <= 1'b0;
            m_cnt   <= L_WORD;
            m_a     <= word1;
            m_b     <= word2;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                product <= 8'(m_a) * 8'(m_b);
            end
            m_cnt <= m_cnt - 1;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every result handshake is matched against the head of the expectation queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (Start) start_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_product", out_product, e.prod);
                    chk("result_tag", out_tag, e.tag);
                end
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] t,
                        input bit track, input int exp_prod);
        bit ok;
        bit got;
        exp_t e;
        got = 1'b0;
        in_word1 = a;
        in_word2 = b;
        in_tag   = t;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            ok = in_ready;
            @(posedge clock);
            if (ok) got = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
        if (got && track) begin
            e.prod = 8'(exp_prod);
            e.tag  = t;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clock);
            k++;
        end
        repeat (2) @(negedge clock);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sc;
        checks      = 0;
        errors      = 0;
        start_cnt   = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_word1    = '0;
        in_word2    = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        force_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_start", Start, 0);
        chk("rst_err", err, 0);
        chk("rst_word1", word1, 0);
        chk("rst_word2", word2, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_out_tag", out_tag, 0);

        // Accept edge closes cycle 0; out_valid in cycle 8 is 7 negedges after that edge.
        sc = start_cnt;
        send(4'd3, 4'd5, 4'd1, 1'b1, 15);
        wait_valid(n);
        chk("t1_latency", n, 7);
        drain("t1_drain");
        chk("t1_start_pulses", start_cnt - sc, 1);
        chk("t1_word1_kept", word1, 3);
        chk("t1_word2_kept", word2, 5);

        // Zero operand bypasses the multiplier: out_valid in cycle 2.
        sc = start_cnt;
        send(4'd0, 4'd9, 4'd2, 1'b1, 0);
        wait_valid(n);
        chk("t2_latency", n, 1);
        drain("t2_drain");
        chk("t2_start_pulses", start_cnt - sc, 0);

        // First job is popped at once, so the 5th push fills the 4-deep FIFO.
        send(4'd15, 4'd15, 4'd0, 1'b1, 225);
        send(4'd1,  4'd1,  4'd1, 1'b1, 1);
        send(4'd2,  4'd7,  4'd2, 1'b1, 14);
        send(4'd0,  4'd0,  4'd3, 1'b1, 0);
        send(4'd4,  4'd4,  4'd4, 1'b1, 16);
        chk("t3_in_ready_full", in_ready, 0);
        drain("t3_drain");
        chk("t3_in_ready_empty", in_ready, 1);

        // Downstream stall in HOLD.
        out_ready = 1'b0;
        send(4'd7, 4'd3, 4'd9, 1'b1, 21);
        wait_valid(n);
        sc = start_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_product", out_product, 21);
            chk("t4_hold_tag", out_tag, 9);
        end
        chk("t4_no_start", start_cnt - sc, 0);
        @(posedge clock);
        #1 out_ready = 1'b1;
        drain("t4_drain");

        // Reset while the first job waits in WAIT_DONE and the FIFO is full.
        send(4'd9, 4'd9, 4'd3, 1'b0, 0);
        send(4'd2, 4'd2, 4'd4, 1'b0, 0);
        send(4'd3, 4'd3, 4'd5, 1'b0, 0);
        send(4'd4, 4'd5, 4'd6, 1'b0, 0);
        send(4'd5, 4'd5, 4'd7, 1'b0, 0);
        chk("t5_full_before_reset", in_ready, 0);
        chk("t5_no_valid_before_reset", out_valid, 0);
        reset = 1'b1;
        #1;
        chk("t5_rst_in_ready", in_ready, 1);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_out_product", out_product, 0);
        chk("t5_rst_out_tag", out_tag, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (15) @(negedge clock);
        chk("t5_fifo_discarded", out_valid, 0);
        chk("t5_in_ready_after", in_ready, 1);
        send(4'd6, 4'd6, 4'd5, 1'b1, 36);
        drain("t5_drain");

        // Ready held high through WAIT_BUSY: sticky error, job dropped.
        force_ready = 1'b1;
        send(4'd2, 4'd3, 4'd6, 1'b0, 0);
        repeat (8) @(negedge clock);
        chk("t6_err_set", err, 1);
        chk("t6_job_dropped", out_valid, 0);
        force_ready = 1'b0;
        repeat (8) @(negedge clock);
        send(4'd3, 4'd3, 4'd7, 1'b1, 9);
        drain("t6_drain");
        chk("t6_err_sticky", err, 1);
        pulse_reset();
        chk("t6_err_cleared", err, 0);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
